// File: rtl/alu_result_checker_pkg.sv
// Shared types for the ALU result checker: opcode and FSM encodings plus the
// delay-pipeline entry carried between sampling and comparison.
package pack_file;

   // Widest ALU result the pipeline entry can carry (WIDTH up to 32).
   localparam int MAX_RES_W = 33;

   typedef enum logic [1:0] {
      ADD    = 2'd0,
      SUB    = 2'd1,
      INV    = 2'd2,
      RED_OR = 2'd3
   } opcode_e;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      RUN    = 2'd1,
      HALT   = 2'd2
   } chk_state_e;

   typedef struct packed {
      logic [MAX_RES_W-1:0] expected;
      logic                 valid;
      opcode_e              opcode;
   } pipe_entry_t;

endpackage

// File: rtl/alu_result_checker_ref.sv
// Golden model of the 4-bit ALU: purely combinational, shared with the bench.
module alu_ref_model
   import pack_file::*;
#(
   parameter int WIDTH = 4
) (
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic        [1:0]       Opcode,
   input  logic                    dut_reset,
   output logic signed [WIDTH:0]   expected
);

   logic signed [WIDTH:0] a_ext;
   logic signed [WIDTH:0] b_ext;

   assign a_ext = {A[WIDTH-1], A};
   assign b_ext = {B[WIDTH-1], B};

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      expected = '0;
      if (!dut_reset) begin
         case (opcode_e'(Opcode))
            ADD:    expected = a_ext + b_ext;
            SUB:    expected = a_ext - b_ext;
            INV:    expected = {1'b0, ~A};
            RED_OR: expected = {{WIDTH{1'b0}}, |B};
         endcase
      end
   end

endmodule

// File: rtl/alu_result_checker.sv
// In-line result checker for the ALU: golden model, LAT-deep delay line, FSM and
// saturating counters. Optional per-opcode coverage under `ALU_CHK_OPCOV_EN.
module alu_result_checker
   import pack_file::*;
#(
   parameter int WIDTH        = 4,
   parameter int LAT          = 1,
   parameter int CNT_W        = 16,
   parameter int STOP_ON_FAIL = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    chk_en,
   input  logic                    dut_reset,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic        [1:0]       Opcode,
   input  logic signed [WIDTH:0]   C,
   output logic        [CNT_W-1:0] check_cnt,
   output logic        [CNT_W-1:0] fail_cnt,
   output logic                    error,
`ifdef ALU_CHK_OPCOV_EN
   output logic                    all_covered,
`endif
   output logic                    halted
);

   localparam int              WU_W    = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic signed [WIDTH:0] expected;
   chk_state_e            state;
   chk_state_e            state_next;
   logic [WU_W-1:0]       wu_cnt;
   logic                  push_en;
   logic                  cmp_en;
   pipe_entry_t           entry_in;
   pipe_entry_t           pipe [LAT];
   pipe_entry_t           head;
   logic                  cmp_fire;
   logic                  mismatch;

   alu_ref_model #(.WIDTH(WIDTH)) u_ref (
      .A         (A),
      .B         (B),
      .Opcode    (Opcode),
      .dut_reset (dut_reset),
      .expected  (expected)
   );

   always_comb begin
      entry_in.expected = MAX_RES_W'($unsigned(expected));
      entry_in.valid    = chk_en & push_en;
      entry_in.opcode   = opcode_e'(Opcode);
   end

   // NOTE: only the valid bits need reset; the payload is ignored until its valid bit arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LAT; i++) pipe[i].valid <= 1'b0;
      end else begin
         pipe[0] <= entry_in;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign head     = pipe[LAT-1];
   assign cmp_fire = cmp_en & head.valid;
   assign mismatch = cmp_fire & (head.expected != MAX_RES_W'($unsigned(C)));

   // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= WARMUP;
         wu_cnt <= '0;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         wu_cnt <= (state == WARMUP) ? wu_cnt + 1'b1 : '0;
         halted <= (state_next == HALT);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         WARMUP:  if (wu_cnt == WU_W'(LAT - 1)) state_next = RUN;
         RUN:     if ((STOP_ON_FAIL != 0) && mismatch) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = WARMUP;
      endcase
   end

   // The pipeline keeps filling during WARMUP so RUN starts with live entries.
   always_comb begin
      push_en = (state != HALT);
      cmp_en  = (state == RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         check_cnt <= '0;
         fail_cnt  <= '0;
         error     <= 1'b0;
      end else if (cmp_fire) begin
         if (check_cnt != CNT_MAX) check_cnt <= check_cnt + 1'b1;
         if (mismatch) begin
            error <= 1'b1;
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
         end
      end
   end

`ifdef ALU_CHK_OPCOV_EN
   logic [LAT-1:0]   cov_pipe;
   logic [CNT_W-1:0] cov_cnt  [4];
   logic [CNT_W-1:0] cov_next [4];

   // Tracks whether each in-flight entry was issued with the ALU out of reset.
   always_ff @(posedge clk) begin
      cov_pipe[0] <= ~dut_reset;
      for (int i = 1; i < LAT; i++) cov_pipe[i] <= cov_pipe[i-1];
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cov_next[i] = cov_cnt[i];
         if (cmp_fire && cov_pipe[LAT-1] && (int'(head.opcode) == i) && (cov_cnt[i] != CNT_MAX))
            cov_next[i] = cov_cnt[i] + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) cov_cnt[i] <= '0;
         all_covered <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) cov_cnt[i] <= cov_next[i];
         all_covered <= (cov_next[0] != '0) && (cov_next[1] != '0) &&
                        (cov_next[2] != '0) && (cov_next[3] != '0);
      end
   end
`else
   logic unused_opcode;
   assign unused_opcode = ^head.opcode;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench for alu_result_checker: the bench plays the ALU, issues checks
// with planned good/bad results and predicts the counters with an edge-level model.
module tb_alu_result_checker;

   localparam int N_DUT = 2;
   localparam int LAT_A = 2;
   localparam int LAT_B = 1;
   localparam int MAXE  = 2048;
   localparam int LAT_OF  [N_DUT] = '{LAT_A, LAT_B};
   localparam int CMAX_OF [N_DUT] = '{15, 65535};
   localparam bit STOP_OF [N_DUT] = '{1'b0, 1'b1};

   typedef struct {
      int issue;
      int due;
      bit bad;
      int op;
      bit dr;
   } rec_t;

   logic              clk = 1'b0;
   logic              reset, chk_en, dut_reset;
   logic signed [3:0] A, B;
   logic        [1:0] Opcode;
   logic signed [4:0] c_a, c_b;
   logic [3:0]        check_cnt_a, fail_cnt_a;
   logic [15:0]       check_cnt_b, fail_cnt_b;
   logic              error_a, error_b, halted_a, halted_b;

   int obs_chk [N_DUT], obs_fail [N_DUT], obs_err [N_DUT], obs_halt [N_DUT];

   rec_t sb [N_DUT][$];
   int   c_hist [N_DUT][MAXE];
   bit   rst_hist [MAXE];
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   int m_chk [N_DUT], m_fail [N_DUT], m_cov [N_DUT][4];
   bit m_err [N_DUT], m_halt [N_DUT];
   int last_rst = 0;

   always #5 clk = ~clk;

   alu_result_checker #(.WIDTH(4), .LAT(LAT_A), .CNT_W(4), .STOP_ON_FAIL(0)) dut_a (
      .clk (clk), .reset (reset), .chk_en (chk_en), .dut_reset (dut_reset),
      .A (A), .B (B), .Opcode (Opcode), .C (c_a),
      .check_cnt (check_cnt_a), .fail_cnt (fail_cnt_a), .error (error_a),
`ifdef ALU_CHK_OPCOV_EN
      .all_covered (all_cov_a),
`endif
      .halted (halted_a)
   );

   alu_result_checker #(.WIDTH(4), .LAT(LAT_B), .CNT_W(16), .STOP_ON_FAIL(1)) dut_b (
      .clk (clk), .reset (reset), .chk_en (chk_en), .dut_reset (dut_reset),
      .A (A), .B (B), .Opcode (Opcode), .C (c_b),
      .check_cnt (check_cnt_b), .fail_cnt (fail_cnt_b), .error (error_b),
`ifdef ALU_CHK_OPCOV_EN
      .all_covered (all_cov_b),
`endif
      .halted (halted_b)
   );

`ifdef ALU_CHK_OPCOV_EN
   logic all_cov_a, all_cov_b;
   int   obs_cov [N_DUT];
   assign obs_cov[0] = int'(all_cov_a);
   assign obs_cov[1] = int'(all_cov_b);
`endif

   assign obs_chk[0]  = int'(check_cnt_a);
   assign obs_fail[0] = int'(fail_cnt_a);
   assign obs_err[0]  = int'(error_a);
   assign obs_halt[0] = int'(halted_a);
   assign obs_chk[1]  = int'(check_cnt_b);
   assign obs_fail[1] = int'(fail_cnt_b);
   assign obs_err[1]  = int'(error_b);
   assign obs_halt[1] = int'(halted_b);

   // Expected ALU result as an integer modulo 32.
   function automatic int ref_res(input int a, input int b, input int op, input bit dr);
      int r;
      if (dr) return 0;
      case (op)
         0:       r = a + b;
         1:       r = a - b;
         2:       r = 15 - (a & 15);
         default: r = (b != 0) ? 1 : 0;
      endcase
      return r & 31;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, got, exp);
      end
   endtask

   // One clock of stimulus; m0/m1 are XOR corruptions of the ALU result per DUT (0 = correct).
   task automatic step(input bit rst, input bit en, input bit dr, input int a, input int b,
                       input int op, input int m0, input int m1);
      int   e;
      int   g;
      rec_t rc;
      e = edge_cnt + 1;
      g = ref_res(a, b, op, dr);
      rst_hist[e]  = rst;
      c_hist[0][e] = g ^ m0;
      c_hist[1][e] = g ^ m1;
      if (en) begin
         for (int d = 0; d < N_DUT; d++) begin
            rc.issue = e;
            rc.due   = e + LAT_OF[d];
            rc.bad   = ((d == 0) ? m0 : m1) != 0;
            rc.op    = op;
            rc.dr    = dr;
            sb[d].push_back(rc);
         end
      end
      reset     = rst;
      chk_en    = en;
      dut_reset = dr;
      A         = a[3:0];
      B         = b[3:0];
      Opcode    = op[1:0];
      c_a       = (e > LAT_A) ? c_hist[0][e-LAT_A][4:0] : 5'd0;
      c_b       = (e > LAT_B) ? c_hist[1][e-LAT_B][4:0] : 5'd0;
      @(posedge clk);
      edge_cnt = e;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
   endtask

   task automatic good_rand(input bit en);
      step(1'b0, en, ($urandom_range(0, 7) == 0), $urandom_range(0, 15) - 8,
           $urandom_range(0, 15) - 8, $urandom_range(0, 3), 0, 0);
   endtask

   task automatic expect_dut(input int d, input int chk, input int fail, input int err,
                             input int hlt, input string tag);
      check($sformatf("%s check_cnt[%0d]", tag, d), obs_chk[d], chk);
      check($sformatf("%s fail_cnt[%0d]", tag, d), obs_fail[d], fail);
      check($sformatf("%s error[%0d]", tag, d), obs_err[d], err);
      check($sformatf("%s halted[%0d]", tag, d), obs_halt[d], hlt);
   endtask

   // Monitor: retire every scoreboard entry due at this edge, then compare all outputs.
   initial begin
      rec_t rc;
      bit   cov_all;
      forever begin
         @(negedge clk);
         if (rst_hist[edge_cnt]) begin
            last_rst = edge_cnt;
            for (int d = 0; d < N_DUT; d++) begin
               m_chk[d] = 0; m_fail[d] = 0; m_err[d] = 1'b0; m_halt[d] = 1'b0;
               for (int k = 0; k < 4; k++) m_cov[d][k] = 0;
            end
         end
         for (int d = 0; d < N_DUT; d++) begin
            while (sb[d].size() > 0 && sb[d][0].due <= edge_cnt) begin
               rc = sb[d].pop_front();
               if (rc.issue > last_rst && !m_halt[d]) begin
                  if (m_chk[d] < CMAX_OF[d]) m_chk[d]++;
                  if (rc.bad) begin
                     m_err[d] = 1'b1;
                     if (m_fail[d] < CMAX_OF[d]) m_fail[d]++;
                     if (STOP_OF[d]) m_halt[d] = 1'b1;
                  end
                  if (!rc.dr && m_cov[d][rc.op] < CMAX_OF[d]) m_cov[d][rc.op]++;
               end
            end
            check($sformatf("mon check_cnt[%0d]", d), obs_chk[d], m_chk[d]);
            check($sformatf("mon fail_cnt[%0d]", d), obs_fail[d], m_fail[d]);
            check($sformatf("mon error[%0d]", d), obs_err[d], int'(m_err[d]));
            check($sformatf("mon halted[%0d]", d), obs_halt[d], int'(m_halt[d]));
`ifdef ALU_CHK_OPCOV_EN
            cov_all = (m_cov[d][0] != 0) && (m_cov[d][1] != 0) &&
                      (m_cov[d][2] != 0) && (m_cov[d][3] != 0);
            check($sformatf("mon all_covered[%0d]", d), obs_cov[d], int'(cov_all));
`endif
         end
      end
   end

   // Driver
   initial begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      expect_dut(0, 0, 0, 0, 0, "reset");
      expect_dut(1, 0, 0, 0, 0, "reset");

      // 7 + 1 = 8
      step(1'b0, 1'b1, 1'b0, 7, 1, 0, 0, 0);
      idle(2);
      expect_dut(0, 1, 0, 0, 0, "add");
      expect_dut(1, 1, 0, 0, 0, "add");
      // -8 - 7 = 5'b10001
      step(1'b0, 1'b1, 1'b0, -8, 7, 1, 0, 0);
      idle(2);
      expect_dut(0, 2, 0, 0, 0, "sub");
      // same stimulus, C forced to 5'b00001: third check fails, stop-on-fail instance halts
      step(1'b0, 1'b1, 1'b0, -8, 7, 1, 16, 16);
      idle(2);
      expect_dut(0, 3, 1, 1, 0, "sub_bad");
      expect_dut(1, 3, 1, 1, 1, "sub_bad");
      // dut_reset overrides opcode: expected 0
      step(1'b0, 1'b1, 1'b1, 5, 3, 0, 0, 0);
      idle(2);
      expect_dut(0, 4, 1, 1, 0, "dutrst");
      step(1'b0, 1'b1, 1'b1, 5, 3, 0, 8, 8);
      idle(2);
      expect_dut(0, 5, 2, 1, 0, "dutrst_bad");
      step(1'b0, 1'b1, 1'b0, $urandom_range(0, 15) - 8, 0, 2, 0, 0);
      step(1'b0, 1'b1, 1'b0, 0, $urandom_range(0, 15) - 8, 3, 0, 0);
      repeat (10) good_rand(1'b1);
      idle(2);
      expect_dut(0, 15, 2, 1, 0, "sat_chk");
      expect_dut(1, 3, 1, 1, 1, "halt_hold");
`ifdef ALU_CHK_OPCOV_EN
      check("all_covered[0]", obs_cov[0], 1);
`endif

      // 20 mismatches on the 4-bit-counter instance
      repeat (20) step(1'b0, 1'b1, 1'b0, $urandom_range(0, 15) - 8, $urandom_range(0, 15) - 8,
                       $urandom_range(0, 3), $urandom_range(1, 31), 0);
      idle(2);
      expect_dut(0, 15, 15, 1, 0, "sat_fail");

      // reset mid-stream with bad entries in flight
      step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      repeat (3) good_rand(1'b1);
      repeat (2) step(1'b0, 1'b1, 1'b0, 3, 2, 0, 5, 5);
      step(1'b1, 1'b1, 1'b0, 3, 2, 0, 7, 7);
      expect_dut(0, 0, 0, 0, 0, "midrst");
      expect_dut(1, 0, 0, 0, 0, "midrst");
      step(1'b0, 1'b1, 1'b0, 2, -3, 1, 0, 0);
      idle(1);
      check("first_cmp check_cnt[0] early", obs_chk[0], 0);
      check("first_cmp check_cnt[1]", obs_chk[1], 1);
      idle(1);
      expect_dut(0, 1, 0, 0, 0, "first_cmp");

      // randomized traffic with occasional checker resets
      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 15) - 8,
              $urandom_range(0, 15) - 8, $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0) ? $urandom_range(1, 31) : 0,
              ($urandom_range(0, 5) == 0) ? $urandom_range(1, 31) : 0);
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Synthesizable in-line checker that sits on the result side of the 4-bit ALU. It samples the stimulus the bench drives into the ALU (A, B, Opcode, DUT reset) and computes the expected result with a golden model. It delays that result to match the ALU latency, compares it against the ALU output C, and keeps pass/fail counters and a sticky error flag. It is the receiving/checking end of the ALU stimulus interface and is instantiated beside the ALU in the bench top.

## Interface
Parameters:
- WIDTH, 4, operand width; C is WIDTH+1 bits, signed.
- LAT, 1, ALU output latency in clk cycles (1..4).
- CNT_W, 16, width of check/fail counters.
- STOP_ON_FAIL, 0, 1 = freeze checking after first mismatch.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high; resets the checker only (not the ALU).
- chk_en  in  1  1 = sample this cycle's stimulus for checking.
- dut_reset  in  1  reset value driven to the ALU this cycle.
- A  in  WIDTH  signed operand A as driven to the ALU.
- B  in  WIDTH  signed operand B as driven to the ALU.
- Opcode  in  2  ALU opcode as driven to the ALU.
- C  in  WIDTH+1  ALU result.
- check_cnt  out  CNT_W  number of comparisons performed, saturating.
- fail_cnt  out  CNT_W  number of mismatches, saturating.
- error  out  1  sticky; set on first mismatch.
- halted  out  1  high in the HALT state.

## Operation
- Golden model, with A and B sign-extended to WIDTH+1:
  - 00: A+B
  - 01: A−B
  - 10: ~A (zero-extended)
  - 11: |B in bit 0, other bits 0
  - dut_reset=1 overrides the opcode → expected 0.
- Each cycle with chk_en=1 in RUN, the checker pushes {expected, valid=1} into a LAT-deep pipeline; with chk_en=0 it pushes valid=0.
- When the pipeline output is valid, the checker compares it with C:
  - check_cnt increments on every comparison.
  - on mismatch, fail_cnt increments and error is set.
- Counters saturate at all-ones; they do not wrap.
- FSM:
  - WARMUP: entered from reset. Stays for LAT cycles while the pipeline fills. No comparisons.
  - WARMUP → RUN after LAT cycles.
  - RUN: normal checking.
  - RUN → HALT on a mismatch when STOP_ON_FAIL=1.
  - HALT: no pushes, no comparisons, counters frozen. Exit only via reset.
- Reset: state=WARMUP, pipeline valid bits cleared, check_cnt=0, fail_cnt=0, error=0, halted=0.
- A mismatch and saturation in the same cycle: fail_cnt stays at max, error is still set.

## Timing
- Stimulus sampled at posedge N is compared against C at posedge N+LAT. The counter update is visible after posedge N+LAT.
- reset asserted mid-stream: in-flight entries are discarded, and no comparison occurs at the edge where reset is high.
- The first comparison after reset deasserts occurs no earlier than LAT+1 edges after the deassertion.
- dut_reset toggling is ordinary data. It does not disturb the checker pipeline.
- All outputs are registered; no combinational path from the inputs to the outputs.

## Configuration
- ALU_CHK_OPCOV_EN defined: adds one CNT_W saturating counter per opcode, incremented on each comparison of that opcode with dut_reset=0. Adds output `all_covered` (1 bit, registered), high once all four counters are nonzero. Reset clears the counters and `all_covered`.
- ALU_CHK_OPCOV_EN undefined: no coverage counters and no `all_covered` port. The rest of the behaviour is identical.

## Structure
- Shared package pack_file holds:
  - `opcode_e` enum: ADD=0, SUB=1, INV=2, RED_OR=3.
  - `chk_state_e` enum: WARMUP, RUN, HALT.
  - the pipeline entry struct {expected, valid, opcode}.
- One combinational sub-module, `alu_ref_model` (A, B, Opcode, dut_reset → expected), so the bench can reuse the golden model.
- Delay pipeline, FSM and counters live in the top module.

## Test plan
- A=7, B=1, Op=00, LAT=1, C=8 one cycle later → check_cnt=1, fail_cnt=0, error=0.
- A=−8, B=7, Op=01, C=5'b10001 → pass. Same stimulus with C forced to 5'b00001 → fail_cnt=1, error=1.
- dut_reset=1 with A=5, B=3, Op=00, C=0 → pass. The same cycle with C=8 → mismatch.
- STOP_ON_FAIL=1, mismatch on the 3rd check, then 10 more good cycles → halted=1, check_cnt=3, fail_cnt=1.
- reset pulsed for 1 cycle after 20 checks, then one check issued → counters 0 after reset. The first comparison occurs LAT+1 edges after deassertion, and no stale entry is compared.
- CNT_W=4, 20 mismatches → fail_cnt=15 held. With ALU_CHK_OPCOV_EN, opcodes 00..11 each issued once → all_covered=1 after the 4th comparison.
